bcd_sub_serial: RTL and testbench

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

---
 rtl/bcd_sub_serial.sv | 133 +++++++++++++
 tb/tb_bcd_sub_serial.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: captures two DIGITS-wide BCD operands and
// produces a - b - bin one digit per cycle, least significant digit first.
module bcd_sub_serial #(
  parameter int DIGITS = 100
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  err
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic [4*DIGITS-1:0] diff_q, diff_d;
  logic                br_q, br_d;
  logic                bout_q, bout_d;
  logic                err_q, err_d;

  logic [3:0]          a_dig, b_dig, res_dig;
  logic [4:0]          t;
  logic                br_new;
  logic                last_dig;

  // Select the operand digits addressed by the counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*4 +: 4];
        b_dig = b_q[i*4 +: 4];
      end
    end
  end

  // a_i - b_i - br lies in -16..15, so a 5-bit two's-complement result suffices;
  // adding 10 modulo 16 on the low nibble gives the borrowed digit.
  always_comb begin
    t       = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, br_q};
    br_new  = t[4];
    res_dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  assign last_dig = (cnt_q == CW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CW'(i)) diff_d[i*4 +: 4] = res_dig;
        end
        br_d = br_new;
        if ((a_dig > 4'd9) || (b_dig > 4'd9)) err_d = 1'b1;
        if (last_dig) begin
          bout_d  = br_new;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed bench for bcd_sub_serial with 4-, 100- and 1-digit instances
// sharing one clock and reset.
module tb_bcd_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset_n;

  logic         iv4, ir4, bin4, ov4, or4, bout4, err4;
  logic [15:0]  a4, b4, diff4;

  logic         iv100, ir100, bin100, ov100, or100, bout100, err100;
  logic [399:0] a100, b100, diff100;

  logic         iv1, ir1, bin1, ov1, or1, bout1, err1;
  logic [3:0]   a1, b1, diff1;

  int cmp_count  = 0;
  int fail_count = 0;

  bcd_sub_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .areset_n(areset_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(or4),
    .diff(diff4), .bout(bout4), .err(err4)
  );

  bcd_sub_serial #(.DIGITS(100)) dut100 (
    .clk(clk), .areset_n(areset_n), .in_valid(iv100), .in_ready(ir100),
    .a(a100), .b(b100), .bin(bin100), .out_valid(ov100), .out_ready(or100),
    .diff(diff100), .bout(bout100), .err(err100)
  );

  bcd_sub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .areset_n(areset_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
    .diff(diff1), .bout(bout1), .err(err1)
  );

  // Entered #1 after an edge with the 4-digit block idle; lat counts cycles
  // from the accept cycle to the first cycle showing out_valid.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi,
                     input logic hold_ready, output int lat,
                     output logic [15:0] d, output logic bo, output logic er);
    a4 = a; b4 = b; bin4 = bi; iv4 = 1'b1; or4 = hold_ready;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 1;
    while (ov4 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d = diff4; bo = bout4; er = err4;
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    $display("op4 a=%h b=%h bin=%b -> diff=%h bout=%b err=%b lat=%0d", a, b, bi, d, bo, er, lat);
  endtask

  task automatic op100(input logic [399:0] a, input logic [399:0] b, input logic bi,
                       output int lat, output logic [399:0] d, output logic bo, output logic er);
    a100 = a; b100 = b; bin100 = bi; iv100 = 1'b1; or100 = 1'b0;
    @(posedge clk); #1;
    iv100 = 1'b0;
    lat = 1;
    while (ov100 !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    d = diff100; bo = bout100; er = err100;
    or100 = 1'b1;
    @(posedge clk); #1;
    or100 = 1'b0;
    $display("op100 bin=%b -> diff=%h bout=%b err=%b lat=%0d", bi, d, bo, er, lat);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     output int lat, output logic [3:0] d, output logic bo, output logic er);
    a1 = a; b1 = b; bin1 = bi; iv1 = 1'b1; or1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 1;
    while (ov1 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = diff1; bo = bout1; er = err1;
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    $display("op1 a=%h b=%h bin=%b -> diff=%h bout=%b err=%b lat=%0d", a, b, bi, d, bo, er, lat);
  endtask

  task automatic test_reset;
    int lat; logic [15:0] d; logic bo, er;
    repeat (2) @(posedge clk);
    #1;
    cmp_count++;
    if ({ir4, ov4, diff4, bout4, err4} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL reset4: got ir=%b ov=%b diff=%h bout=%b err=%b want ir=1 ov=0 diff=0000 bout=0 err=0",
               ir4, ov4, diff4, bout4, err4);
    end
    cmp_count++;
    if ({ir100, ov100, diff100, bout100, err100} !== {1'b1, 1'b0, 400'd0, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL reset100: got ir=%b ov=%b bout=%b err=%b want ir=1 ov=0 diff=0 bout=0 err=0",
               ir100, ov100, bout100, err100);
    end
    areset_n = 1'b1;
    op4(16'h0321, 16'h0123, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if (lat !== 5) begin
      fail_count++;
      $display("FAIL first_accept_latency: got %0d want 5", lat);
    end
    cmp_count++;
    if ({d, bo, er} !== {16'h0198, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL first_accept_result: got diff=%h bout=%b err=%b want 0198/0/0", d, bo, er);
    end
  endtask

  task automatic test_latency;
    int lat; logic [15:0] d; logic bo, er;
    op4(16'h1000, 16'h0001, 1'b0, 1'b1, lat, d, bo, er);
    cmp_count++;
    if (lat !== 5) begin
      fail_count++;
      $display("FAIL latency4: got %0d want 5", lat);
    end
    cmp_count++;
    if ({d, bo, er} !== {16'h0999, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL result_1000_0001: got diff=%h bout=%b err=%b want 0999/0/0", d, bo, er);
    end
    cmp_count++;
    if ({ir4, ov4} !== 2'b10) begin
      fail_count++;
      $display("FAIL idle_after_accept: got ir=%b ov=%b want ir=1 ov=0", ir4, ov4);
    end
  endtask

  task automatic test_borrow;
    int lat; logic [15:0] d; logic bo, er;
    op4(16'h0000, 16'h0000, 1'b1, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo} !== {16'h9999, 1'b1}) begin
      fail_count++;
      $display("FAIL zero_minus_bin: got diff=%h bout=%b want 9999/1", d, bo);
    end
    op4(16'h0005, 16'h0007, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo} !== {16'h9998, 1'b1}) begin
      fail_count++;
      $display("FAIL 5_minus_7: got diff=%h bout=%b want 9998/1", d, bo);
    end
    op4(16'h1234, 16'h5678, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er} !== {16'h5556, 1'b1, 1'b0}) begin
      fail_count++;
      $display("FAIL 1234_minus_5678: got diff=%h bout=%b err=%b want 5556/1/0", d, bo, er);
    end
  endtask

  task automatic test_err;
    int lat; logic [15:0] d; logic bo, er;
    op4(16'h00A3, 16'h0001, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er} !== {16'h00A2, 1'b0, 1'b1}) begin
      fail_count++;
      $display("FAIL bad_nibble: got diff=%h bout=%b err=%b want 00A2/0/1", d, bo, er);
    end
    op4(16'h5678, 16'h1234, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er} !== {16'h4444, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL err_cleared: got diff=%h bout=%b err=%b want 4444/0/0", d, bo, er);
    end
  endtask

  task automatic test_hold;
    int lat; logic [15:0] d; logic bo, er;
    int waited;
    a4 = 16'h0042; b4 = 16'h0017; bin4 = 1'b0; iv4 = 1'b1; or4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    waited = 0;
    while (ov4 !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int i = 0; i < 10; i++) begin
      a4 = ~a4; b4 = b4 ^ 16'h5A5A; iv4 = ~iv4;
      @(posedge clk); #1;
      cmp_count++;
      if ({ov4, ir4, diff4, bout4, err4} !== {1'b1, 1'b0, 16'h0025, 1'b0, 1'b0}) begin
        fail_count++;
        $display("FAIL done_hold[%0d]: got ov=%b ir=%b diff=%h bout=%b err=%b want 1/0/0025/0/0",
                 i, ov4, ir4, diff4, bout4, err4);
      end
    end
    $display("hold a=0042 b=0017 -> diff=%h bout=%b err=%b held 10 cycles", diff4, bout4, err4);
    iv4 = 1'b0; or4 = 1'b1;
    #1;
    cmp_count++;
    if (ir4 !== 1'b0) begin
      fail_count++;
      $display("FAIL no_ready_on_handshake: got in_ready=%b want 0", ir4);
    end
    @(posedge clk); #1;
    or4 = 1'b0;
    cmp_count++;
    if ({ir4, ov4} !== 2'b10) begin
      fail_count++;
      $display("FAIL idle_after_release: got ir=%b ov=%b want ir=1 ov=0", ir4, ov4);
    end
    op4(16'h0500, 16'h0499, 1'b1, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er, lat} !== {16'h0000, 1'b0, 1'b0, 32'd5}) begin
      fail_count++;
      $display("FAIL after_hold: got diff=%h bout=%b err=%b lat=%0d want 0000/0/0/5", d, bo, er, lat);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [15:0] d; logic bo, er;
    logic saw_valid;
    a4 = 16'h432B; b4 = 16'h1234; bin4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    areset_n = 1'b0;
    #1;
    cmp_count++;
    if ({ir4, ov4, diff4, bout4, err4} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL async_reset: got ir=%b ov=%b diff=%h bout=%b err=%b want 1/0/0000/0/0",
               ir4, ov4, diff4, bout4, err4);
    end
    @(posedge clk); #1;
    areset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov4 === 1'b1) saw_valid = 1'b1;
    end
    or4 = 1'b0;
    $display("reset mid-run: out_valid seen afterwards=%b", saw_valid);
    cmp_count++;
    if (saw_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL abandoned_result: got out_valid pulse=%b want 0", saw_valid);
    end
    op4(16'h4321, 16'h1234, 1'b0, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er, lat} !== {16'h3087, 1'b0, 1'b0, 32'd5}) begin
      fail_count++;
      $display("FAIL after_reset: got diff=%h bout=%b err=%b lat=%0d want 3087/0/0/5", d, bo, er, lat);
    end
  endtask

  task automatic test_wide;
    int lat; logic [399:0] d; logic bo, er;
    logic [399:0] nines;
    for (int i = 0; i < 100; i++) nines[i*4 +: 4] = 4'h9;
    op100(nines, nines, 1'b1, lat, d, bo, er);
    cmp_count++;
    if (lat !== 101) begin
      fail_count++;
      $display("FAIL latency100: got %0d want 101", lat);
    end
    cmp_count++;
    if ({d, bo, er} !== {nines, 1'b1, 1'b0}) begin
      fail_count++;
      $display("FAIL nines100: got diff=%h bout=%b err=%b want all 9s/1/0", d, bo, er);
    end
  endtask

  task automatic test_single;
    int lat; logic [3:0] d; logic bo, er;
    op1(4'h3, 4'h5, 1'b0, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, lat} !== {4'h8, 1'b1, 32'd2}) begin
      fail_count++;
      $display("FAIL single_3_minus_5: got diff=%h bout=%b lat=%0d want 8/1/2", d, bo, lat);
    end
    op1(4'h9, 4'h2, 1'b1, lat, d, bo, er);
    cmp_count++;
    if ({d, bo, er} !== {4'h6, 1'b0, 1'b0}) begin
      fail_count++;
      $display("FAIL single_9_minus_2_bin: got diff=%h bout=%b err=%b want 6/0/0", d, bo, er);
    end
  endtask

  initial begin
    areset_n = 1'b0;
    iv4 = 1'b0;   or4 = 1'b0;   bin4 = 1'b0;   a4 = '0;   b4 = '0;
    iv100 = 1'b0; or100 = 1'b0; bin100 = 1'b0; a100 = '0; b100 = '0;
    iv1 = 1'b0;   or1 = 1'b0;   bin1 = 1'b0;   a1 = '0;   b1 = '0;

    test_reset;
    test_latency;
    test_borrow;
    test_err;
    test_hold;
    test_reset_mid_run;
    test_wide;
    test_single;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
